// File: rtl/plcp_tx_sequencer.sv
// plcp_tx_sequencer
// Sequences an external 7-bit 802.11b scrambler (x^7+x^4+1, combinational
// output) through one long-preamble PPDU: SYNC ones, SFD, PLCP header with
// CRC-16, then PSDU bytes pulled from an upstream byte stream. One bit is
// advanced per bit_tick and the scrambled bit is registered toward the
// modulator.
//
// Ports
//   clock, reset       system clock / async active-high reset
//   bit_tick           one bit advances per strobe
//   start              frame request, honoured only while idle
//   signal_in, service_in, length_in, psdu_bytes
//                      header fields and PSDU byte count, latched on start
//   pay_data/pay_valid/pay_ready
//                      upstream byte handshake (ready only on byte-boundary ticks)
//   scr_reset, scr_enable, scr_bit_in, scr_bit_out
//                      scrambler control and its combinational output
//   tx_bit, tx_valid   registered scrambled bit and its one-cycle strobe
//   busy, done, underrun
//                      frame in progress, normal end pulse, abort pulse
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; scrambler reset released
// CLR   | one clock of scrambler reset so SYNC starts from zero state
// SYNC  | SYNC_LEN ones
// SFD   | 16-bit start-frame delimiter, LSB first
// HDR   | SIGNAL, SERVICE, LENGTH (LSB first) then ~CRC16 MSB first
// PSDU  | payload bytes LSB first; byte fetched on its first tick
module plcp_tx_sequencer #(
    parameter int          SYNC_LEN = 128,
    parameter logic [15:0] SFD      = 16'hF3A0,
    parameter int          LEN_W    = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bit_tick,
    input  logic             start,
    input  logic [7:0]       signal_in,
    input  logic [7:0]       service_in,
    input  logic [15:0]      length_in,
    input  logic [LEN_W-1:0] psdu_bytes,
    input  logic [7:0]       pay_data,
    input  logic             pay_valid,
    output logic             pay_ready,
    output logic             scr_reset,
    output logic             scr_enable,
    output logic             scr_bit_in,
    input  logic             scr_bit_out,
    output logic             tx_bit,
    output logic             tx_valid,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    localparam int CNT_MAX = (SYNC_LEN > 48) ? SYNC_LEN : 48;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CLR  = 3'd1;
    localparam logic [2:0] ST_SYNC = 3'd2;
    localparam logic [2:0] ST_SFD  = 3'd3;
    localparam logic [2:0] ST_HDR  = 3'd4;
    localparam logic [2:0] ST_PSDU = 3'd5;

    logic [2:0]       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [LEN_W-1:0] byte_cnt;
    logic [31:0]      hdr_sr;
    logic [15:0]      crc;
    logic [6:0]       pay_sr;

    logic       hdr_field;
    logic       byte_first;
    logic       emitting;
    logic       emit;
    logic       cur_bit;
    logic [3:0] sfd_idx;

    always_comb begin
        // bit_cnt counts 47..0 in HDR: 47..16 are header field bits, 15..0 CRC
        hdr_field  = (bit_cnt >= CNT_W'(16));
        byte_first = (state == ST_PSDU) && (bit_cnt == CNT_W'(7));
        // SFD counter runs 15..0, so the LSB-first index is its complement
        sfd_idx    = ~bit_cnt[3:0];
        cur_bit    = 1'b0;
        case (state)
            ST_SYNC: cur_bit = 1'b1;
            ST_SFD:  cur_bit = SFD[sfd_idx];
            ST_HDR:  cur_bit = hdr_field ? hdr_sr[0] : ~crc[15];
            ST_PSDU: cur_bit = byte_first ? pay_data[0] : pay_sr[0];
            default: cur_bit = 1'b0;
        endcase
        emitting = (state == ST_SYNC) || (state == ST_SFD) ||
                   (state == ST_HDR)  || (state == ST_PSDU);
        // a byte-boundary tick with no data is an underrun, not a bit
        emit     = bit_tick && emitting && !(byte_first && !pay_valid);
    end

    assign pay_ready  = bit_tick && byte_first;
    assign scr_enable = emit;
    assign scr_bit_in = emit & cur_bit;
    // reset term keeps the scrambler held while this block is in reset
    assign scr_reset  = reset | (state == ST_CLR);
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            hdr_sr   <= '0;
            crc      <= '0;
            pay_sr   <= '0;
            tx_bit   <= 1'b0;
            tx_valid <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            tx_valid <= emit;
            done     <= 1'b0;
            underrun <= 1'b0;
            if (emit) begin
                tx_bit <= scr_bit_out;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        hdr_sr   <= {length_in, service_in, signal_in};
                        byte_cnt <= psdu_bytes;
                        crc      <= 16'hFFFF;
                        state    <= ST_CLR;
                    end
                end
                ST_CLR: begin
                    bit_cnt <= CNT_W'(SYNC_LEN - 1);
                    state   <= ST_SYNC;
                end
                ST_SYNC: begin
                    if (bit_tick) begin
                        if (bit_cnt == '0) begin
                            bit_cnt <= CNT_W'(15);
                            state   <= ST_SFD;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end
                ST_SFD: begin
                    if (bit_tick) begin
                        if (bit_cnt == '0) begin
                            bit_cnt <= CNT_W'(47);
                            state   <= ST_HDR;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end
                ST_HDR: begin
                    if (bit_tick) begin
                        if (hdr_field) begin
                            hdr_sr <= {1'b0, hdr_sr[31:1]};
                            crc    <= {crc[14:0], 1'b0} ^
                                      ((crc[15] ^ hdr_sr[0]) ? 16'h1021 : 16'h0000);
                        end else begin
                            // CRC phase: shift the register out MSB first
                            crc <= {crc[14:0], 1'b0};
                        end
                        if (bit_cnt == '0) begin
                            if (byte_cnt == '0) begin
                                done  <= 1'b1;
                                state <= ST_IDLE;
                            end else begin
                                bit_cnt <= CNT_W'(7);
                                state   <= ST_PSDU;
                            end
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end
                ST_PSDU: begin
                    if (bit_tick) begin
                        if (byte_first) begin
                            if (pay_valid) begin
                                pay_sr  <= pay_data[7:1];
                                bit_cnt <= CNT_W'(6);
                            end else begin
                                underrun <= 1'b1;
                                state    <= ST_IDLE;
                            end
                        end else begin
                            pay_sr <= {1'b0, pay_sr[6:1]};
                            if (bit_cnt == '0) begin
                                if (byte_cnt == LEN_W'(1)) begin
                                    done  <= 1'b1;
                                    state <= ST_IDLE;
                                end else begin
                                    byte_cnt <= byte_cnt - 1'b1;
                                    bit_cnt  <= CNT_W'(7);
                                end
                            end else begin
                                bit_cnt <= bit_cnt - 1'b1;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
